timer_apb_sequencer: RTL and testbench

//  APB master that programs and controls the timer peripheral (TCR@0x0, TCNT@0x4, PSC@0x8, ARR@0xC).

---
 rtl/timer_seq_pkg.sv | 76 +++++++
 rtl/tseq_apb_xfer.sv | 105 ++++++++++
 rtl/timer_apb_sequencer.sv | 145 ++++++++++++++
 tb/tb_timer_apb_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_seq_pkg.sv
// Shared types and the per-command step table for the timer APB sequencer.
// TSEQ_READBACK_EN appends PSC/ARR readback reads to START.
package timer_seq_pkg;

    typedef enum logic [1:0] {
        OP_START    = 2'd0,
        OP_STOP     = 2'd1,
        OP_RESTART  = 2'd2,
        OP_READ_CNT = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS
    } xfer_state_t;

    localparam logic [3:0] ADDR_TCR  = 4'h0;
    localparam logic [3:0] ADDR_TCNT = 4'h4;
    localparam logic [3:0] ADDR_PSC  = 4'h8;
    localparam logic [3:0] ADDR_ARR  = 4'hC;

    localparam logic [31:0] TCR_EN  = 32'h1;
    localparam logic [31:0] TCR_CLR = 32'h2;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [3:0]  addr;
        logic [31:0] data;
    } step_t;

    function automatic step_t mk_step(logic write, logic [3:0] addr, logic [31:0] data);
        return {1'b1, write, addr, data};
    endfunction

    // For read steps, data carries the value the readback is expected to return.
    function automatic step_t step_lookup(op_t op, logic [2:0] idx,
                                          logic [31:0] psc, logic [31:0] arr);
        step_t s;
        s = '0;
        case (op)
            OP_START: begin
                case (idx)
                    3'd0: s = mk_step(1'b1, ADDR_TCR, TCR_CLR);
                    3'd1: s = mk_step(1'b1, ADDR_PSC, psc);
                    3'd2: s = mk_step(1'b1, ADDR_ARR, arr);
                    3'd3: s = mk_step(1'b1, ADDR_TCR, TCR_EN);
`ifdef TSEQ_READBACK_EN
                    3'd4: s = mk_step(1'b0, ADDR_PSC, psc);
                    3'd5: s = mk_step(1'b0, ADDR_ARR, arr);
`endif
                    default: s = '0;
                endcase
            end
            OP_STOP: begin
                if (idx == 3'd0) s = mk_step(1'b1, ADDR_TCR, 32'h0);
            end
            OP_RESTART: begin
                if (idx == 3'd0) s = mk_step(1'b1, ADDR_TCR, TCR_EN | TCR_CLR);
                else if (idx == 3'd1) s = mk_step(1'b1, ADDR_TCR, TCR_EN);
            end
            default: begin
                if (idx == 3'd0) s = mk_step(1'b0, ADDR_TCNT, 32'h0);
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tseq_apb_xfer.sv
// Single APB transfer engine: SETUP/ACCESS, PREADY wait with timeout, read capture.
// A start presented together with ack chains straight into the next SETUP.
module tseq_apb_xfer
    import timer_seq_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic        wr,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        timeout,
    output logic [31:0] rd_data,
    output logic [3:0]  PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    xfer_state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    paddr_reg, paddr_next;
    logic [31:0]   pwdata_reg, pwdata_next;
    logic          pwrite_reg, pwrite_next;
    logic [31:0]   rd_data_reg, rd_data_next;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg   <= X_IDLE;
            cnt_reg     <= '0;
            paddr_reg   <= '0;
            pwdata_reg  <= '0;
            pwrite_reg  <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            paddr_reg   <= paddr_next;
            pwdata_reg  <= pwdata_next;
            pwrite_reg  <= pwrite_next;
            rd_data_reg <= rd_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        paddr_next   = paddr_reg;
        pwdata_next  = pwdata_reg;
        pwrite_next  = pwrite_reg;
        rd_data_next = rd_data_reg;
        ack          = 1'b0;
        timeout      = 1'b0;
        case (state_reg)
            X_IDLE: begin
                if (start) begin
                    state_next  = X_SETUP;
                    paddr_next  = addr;
                    pwdata_next = wdata;
                    pwrite_next = wr;
                end
            end
            X_SETUP: begin
                state_next = X_ACCESS;
                cnt_next   = '0;
            end
            X_ACCESS: begin
                if (PREADY) begin
                    ack = 1'b1;
                    if (!pwrite_reg) rd_data_next = PRDATA;
                    if (start) begin
                        state_next  = X_SETUP;
                        paddr_next  = addr;
                        pwdata_next = wdata;
                        pwrite_next = wr;
                    end else begin
                        state_next = X_IDLE;
                    end
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    // cnt_reg counts stalled ACCESS cycles already spent
                    timeout    = 1'b1;
                    state_next = X_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = X_IDLE;
        endcase
    end

    assign PSEL    = (state_reg != X_IDLE);
    assign PENABLE = (state_reg == X_ACCESS);
    assign PADDR   = paddr_reg;
    assign PWDATA  = pwdata_reg;
    assign PWRITE  = pwrite_reg;
    assign rd_data = rd_data_reg;

endmodule

// File: rtl/timer_apb_sequencer.sv
// Expands one-word timer commands into APB transfer sequences via a step table.
// Optional TSEQ_READBACK_EN: START verifies PSC/ARR by reading them back.
module timer_apb_sequencer
    import timer_seq_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_psc,
    input  logic [31:0] cmd_arr,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [3:0]  PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);
    state_t      state_reg, state_next;
    op_t         op_reg, op_next;
    logic [31:0] psc_reg, psc_next;
    logic [31:0] arr_reg, arr_next;
    logic [2:0]  step_reg, step_next;
    logic        err_reg, err_next;
    logic [31:0] rdata_reg, rdata_next;

    step_t       first_step, next_step, launch;
    logic        xfer_start, xfer_ack, xfer_timeout, readback_bad;
    logic [31:0] xfer_rd_data;

    assign first_step = step_lookup(op_t'(cmd_op), 3'd0, cmd_psc, cmd_arr);
    assign next_step  = step_lookup(op_reg, step_reg + 3'd1, psc_reg, arr_reg);
    assign launch     = (state_reg == S_IDLE) ? first_step : next_step;

`ifdef TSEQ_READBACK_EN
    step_t cur_step;
    assign cur_step     = step_lookup(op_reg, step_reg, psc_reg, arr_reg);
    assign readback_bad = xfer_ack && cur_step.valid && !cur_step.write &&
                          (cur_step.addr != ADDR_TCNT) && (PRDATA != cur_step.data);
`else
    assign readback_bad = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_START;
            psc_reg   <= '0;
            arr_reg   <= '0;
            step_reg  <= '0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            psc_reg   <= psc_next;
            arr_reg   <= arr_next;
            step_reg  <= step_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        psc_next   = psc_reg;
        arr_next   = arr_reg;
        step_next  = step_reg;
        err_next   = err_reg;
        rdata_next = rdata_reg;
        xfer_start = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_next   = op_t'(cmd_op);
                    psc_next  = cmd_psc;
                    arr_next  = cmd_arr;
                    step_next = 3'd0;
                    if (op_t'(cmd_op) == OP_START && cmd_psc == 32'h0) begin
                        state_next = S_DONE;
                        err_next   = 1'b1;
                    end else begin
                        state_next = S_RUN;
                        err_next   = 1'b0;
                        xfer_start = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (xfer_timeout) begin
                    state_next = S_DONE;
                    err_next   = 1'b1;
                end else if (xfer_ack) begin
                    err_next = err_reg | readback_bad;
                    if (next_step.valid) begin
                        xfer_start = 1'b1;
                        step_next  = step_reg + 3'd1;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                if (op_reg == OP_READ_CNT && !err_reg) rdata_next = xfer_rd_data;
            end
            default: state_next = S_IDLE;
        endcase
    end

    tseq_apb_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .start   (xfer_start),
        .wr      (launch.write),
        .addr    (launch.addr),
        .wdata   (launch.data),
        .ack     (xfer_ack),
        .timeout (xfer_timeout),
        .rd_data (xfer_rd_data),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    assign cmd_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign err       = (state_reg == S_DONE) && err_reg;
    assign rdata     = rdata_reg;

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Bench for timer_apb_sequencer: timer slave stub, expected-transfer queue, per-cycle monitor.
module tb_timer_apb_sequencer;
    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_psc = 32'h0, cmd_arr = 32'h0;
    logic        cmd_ready, busy, done, err;
    logic [31:0] rdata;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY;

    always #5 PCLK = ~PCLK;

    timer_apb_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_psc(cmd_psc), .cmd_arr(cmd_arr),
        .cmd_ready(cmd_ready), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    // Timer slave stub: registered PREADY (2nd ACCESS cycle), CLR holds count at 0.
    logic [31:0] s_tcr, s_psc, s_arr, s_tcnt, s_pcnt;
    logic        stall = 1'b0;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PREADY <= 1'b0; s_tcr <= '0; s_psc <= '0; s_arr <= '0; s_tcnt <= '0; s_pcnt <= '0;
        end else begin
            PREADY <= PSEL && PENABLE && !PREADY && !stall;
            if (PSEL && PENABLE && PREADY && PWRITE) begin
                case (PADDR)
                    4'h0: s_tcr <= PWDATA;
                    4'h8: s_psc <= PWDATA;
                    4'hC: s_arr <= PWDATA;
                    default: ;
                endcase
            end
            if (s_tcr[1]) begin
                s_tcnt <= '0; s_pcnt <= '0;
            end else if (s_tcr[0]) begin
                if (s_pcnt + 32'd1 >= s_psc) begin
                    s_pcnt <= '0;
                    s_tcnt <= (s_tcnt >= s_arr) ? 32'd0 : s_tcnt + 32'd1;
                end else begin
                    s_pcnt <= s_pcnt + 32'd1;
                end
            end
        end
    end

    always_comb begin
        case (PADDR)
            4'h0: PRDATA = s_tcr;
            4'h4: PRDATA = s_tcnt;
            4'h8: PRDATA = s_psc;
            4'hC: PRDATA = s_arr;
            default: PRDATA = 32'h0;
        endcase
    end

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    xfer_t       wlog[$];
    int          checks = 0;
    int          passes = 0;
    int          psel_cycles = 0;
    int          access_stall = 0;
    logic [31:0] exp_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic push(input logic wr, input logic [3:0] addr, input logic [31:0] data);
        xfer_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    // What the timer must see for each command, straight from the command definitions.
    task automatic expect_cmd(input logic [1:0] op, input logic [31:0] psc, input logic [31:0] arr);
        case (op)
            2'd0: if (psc != 0) begin
                push(1, 4'h0, 32'd2); push(1, 4'h8, psc); push(1, 4'hC, arr); push(1, 4'h0, 32'd1);
`ifdef TSEQ_READBACK_EN
                push(0, 4'h8, psc); push(0, 4'hC, arr);
`endif
            end
            2'd1: push(1, 4'h0, 32'd0);
            2'd2: begin push(1, 4'h0, 32'd3); push(1, 4'h0, 32'd1); end
            default: push(0, 4'h4, 32'd0);
        endcase
    endtask

    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (PSEL) psel_cycles++;
            if (PSEL && PENABLE && !PREADY) access_stall++;
            chk("ready_vs_busy", cmd_ready, !busy);
            chk("penable_needs_psel", PENABLE & ~PSEL, 1'b0);
            if (done) chk("done_bus_idle", PSEL, 1'b0);
            if (err) chk("err_only_with_done", done, 1'b1);
            if (PSEL && PENABLE && PREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_xfer actual addr=%h wr=%b required none", PADDR, PWRITE);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    chk("xfer_dir", PWRITE, e.wr);
                    chk("xfer_addr", PADDR, e.addr);
                    if (e.wr) begin
                        chk("xfer_wdata", PWDATA, e.data);
                        wlog.push_back(e);
                    end else if (e.addr == 4'h4) begin
                        exp_rdata = PRDATA;
                    end
                end
            end
        end
    end

    task automatic do_cmd(input string name, input logic [1:0] op, input logic [31:0] psc,
                          input logic [31:0] arr, input logic exp_err, output int lat);
        int n, exp_lat;
        exp_q = {};
        if (!stall) expect_cmd(op, psc, arr);
        n = exp_q.size();
        exp_lat = stall ? 2 + TIMEOUT : 1 + 3 * n;
        @(posedge PCLK); #1;
        psel_cycles = 0; access_stall = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_psc = psc; cmd_arr = arr;
        chk({name, "_ready"}, cmd_ready, 1'b1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_psc = 32'hDEAD_BEEF; cmd_arr = 32'h1234_5678;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge PCLK);
            if (done) begin lat = c; break; end
        end
        if (lat == 0) begin
            checks++;
            $display("FAIL %s_no_done actual=none required=done within 200 cycles", name);
        end else begin
            chk({name, "_latency"}, lat, exp_lat);
            chk({name, "_err"}, err, exp_err);
            chk({name, "_all_xfers"}, exp_q.size(), 0);
        end
        @(negedge PCLK);
        $display("cmd %s op=%0d psc=%0d arr=%0d latency=%0d err=%b rdata=%0d",
                 name, op, psc, arr, lat, exp_err, rdata);
        chk({name, "_ready_after"}, cmd_ready, 1'b1);
        chk({name, "_done_one_cycle"}, done, 1'b0);
        exp_q = {};
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_psel"}, PSEL, 1'b0);
        chk({name, "_penable"}, PENABLE, 1'b0);
        chk({name, "_pwrite"}, PWRITE, 1'b0);
        chk({name, "_paddr"}, PADDR, 4'h0);
        chk({name, "_pwdata"}, PWDATA, 32'h0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_err"}, err, 1'b0);
        chk({name, "_rdata"}, rdata, 32'h0);
        chk({name, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    initial begin
        int lat, found;
        logic [31:0] frozen;
        repeat (3) @(negedge PCLK);
        check_reset_outputs("reset");
        PRESET = 1'b0;

        // START psc=10 arr=5
        wlog = {};
        do_cmd("start", 2'd0, 32'd10, 32'd5, 1'b0, lat);
`ifdef TSEQ_READBACK_EN
        chk("start_latency_literal", lat, 19);
`else
        chk("start_latency_literal", lat, 13);
`endif
        if (wlog.size() == 4) begin
            chk("start_w0_literal", wlog[0].data, 32'd2);
            chk("start_w1_literal", wlog[1].data, 32'd10);
            chk("start_w2_literal", wlog[2].data, 32'd5);
            chk("start_w3_literal", wlog[3].data, 32'd1);
        end else begin
            chk("start_write_count", wlog.size(), 4);
        end
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge PCLK);
            if (s_tcnt == 32'd5) begin found = 1; break; end
        end
        chk("tcnt_reaches_arr", found, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge PCLK);
            if (s_tcnt != 32'd5) break;
        end
        chk("tcnt_wraps_to_0", s_tcnt, 32'd0);

        // READ_CNT after the timer has run
        repeat (200) @(negedge PCLK);
        do_cmd("read_cnt", 2'd3, 32'd0, 32'd0, 1'b0, lat);
        chk("read_cnt_rdata", rdata, exp_rdata);
        chk("read_cnt_psel_cycles", psel_cycles, 3);
        chk("read_cnt_latency_literal", lat, 4);

        // STOP freezes, RESTART clears and resumes
        do_cmd("stop", 2'd1, 32'd0, 32'd0, 1'b0, lat);
        frozen = s_tcnt;
        repeat (30) @(negedge PCLK);
        chk("stop_frozen", s_tcnt, frozen);
        do_cmd("restart", 2'd2, 32'd0, 32'd0, 1'b0, lat);
        chk("restart_tcnt_cleared", s_tcnt, 32'd0);
        repeat (50) @(negedge PCLK);
        chk("restart_counts_again", s_tcnt > 0, 1'b1);

        // START with psc=0 is rejected
        do_cmd("start_psc0", 2'd0, 32'd0, 32'd7, 1'b1, lat);
        chk("psc0_latency_literal", lat, 1);
        chk("psc0_no_psel", psel_cycles, 0);
        chk("psc0_rdata_kept", rdata, exp_rdata);

        // Slave never ready -> timeout
        stall = 1'b1;
        do_cmd("timeout", 2'd1, 32'd0, 32'd0, 1'b1, lat);
        stall = 1'b0;
        chk("timeout_latency_literal", lat, 18);
        chk("timeout_access_cycles", access_stall, 16);

        // PRESET during the 2nd write of START
        exp_q = {};
        expect_cmd(2'd0, 32'd10, 32'd5);
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_psc = 32'd10; cmd_arr = 32'd5;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge PCLK);
            if (PSEL && !PENABLE && PADDR == 4'h8) begin found = 1; break; end
        end
        chk("mid_reset_reached_w2", found, 1);
        #2 PRESET = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        exp_q = {};
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        $display("cmd mid_reset_abort op=0 psc=10 arr=5");
        do_cmd("start_after_reset", 2'd0, 32'd10, 32'd5, 1'b0, lat);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
